// File: rtl/uart_puf_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_puf_cmd_ctrl
//
// Command sequencer between a UART receiver and an RO-PUF core. Host frames
// have the form SYNC, CMD, [payload], CHK:
//   CMD 8'h01 RUN   : CHAL_BYTES payload bytes follow; on a good checksum the
//                     payload is loaded as the challenge and the PUF started.
//   CMD 8'h02 CLEAR : no payload; on a good checksum the PUF is soft-cleared.
// CHK is the XOR of CMD and all payload bytes. Rejected frames, stalled
// frames, PUF timeouts and bytes arriving while the PUF runs are all errors.
//
// Ports
//   i_Clock      in   system clock, rising edge
//   i_Reset      in   asynchronous active-high reset
//   i_Rx_DV      in   one-cycle strobe, i_Rx_Byte valid
//   i_Rx_Byte    in   received byte
//   i_Puf_Done   in   PUF measurement complete (level or pulse)
//   o_Challenge  out  latched challenge, byte 0 in [7:0]
//   o_Puf_Start  out  one-cycle PUF start pulse
//   o_Puf_Clear  out  one-cycle PUF soft-clear pulse
//   o_Busy       out  high while a PUF measurement is outstanding
//   o_Frame_Err  out  one-cycle pulse per error event
//   o_Err_Count  out  saturating error counter
// ---------------------------------------------------------------------------
module uart_puf_cmd_ctrl #(
  parameter int unsigned CHAL_BYTES   = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned BYTE_TIMEOUT = 100000,
  parameter int unsigned PUF_TIMEOUT  = 1000000
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic                    i_Rx_DV,
  input  logic [7:0]              i_Rx_Byte,
  input  logic                    i_Puf_Done,
  output logic [8*CHAL_BYTES-1:0] o_Challenge,
  output logic                    o_Puf_Start,
  output logic                    o_Puf_Clear,
  output logic                    o_Busy,
  output logic                    o_Frame_Err,
  output logic [7:0]              o_Err_Count
);

  localparam int IDX_W = $clog2(CHAL_BYTES + 1);
  localparam int BT_W  = $clog2(BYTE_TIMEOUT);
  localparam int PT_W  = $clog2(PUF_TIMEOUT);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHAL_BYTES - 1);
  localparam logic [BT_W-1:0]  BT_LAST  = BT_W'(BYTE_TIMEOUT - 1);
  localparam logic [PT_W-1:0]  PT_LAST  = PT_W'(PUF_TIMEOUT - 1);

  localparam logic [7:0] CMD_RUN   = 8'h01;
  localparam logic [7:0] CMD_CLEAR = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_PAYLOAD,
    S_CHK,
    S_WAIT
  } state_t;

  state_t                  state, state_nxt;
  logic [7:0]              cmd_q;
  logic [7:0]              xor_q;
  logic [IDX_W-1:0]        idx_q;
  logic [BT_W-1:0]         byte_tmr_q;
  logic [PT_W-1:0]         puf_tmr_q;
  logic [8*CHAL_BYTES-1:0] shadow_q;

  logic in_frame;
  logic byte_tmo;
  logic puf_tmo;
  logic err_nxt;
  logic start_nxt;
  logic clear_nxt;
  logic load_chal;

  assign in_frame = (state == S_CMD) || (state == S_PAYLOAD) || (state == S_CHK);
  assign byte_tmo = (byte_tmr_q == BT_LAST);
  assign puf_tmo  = (puf_tmr_q == PT_LAST);
  assign o_Busy   = (state == S_WAIT);

  // -------------------------------------------------------------------------
  // Next-state and strobe decode
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    err_nxt   = 1'b0;
    start_nxt = 1'b0;
    clear_nxt = 1'b0;
    load_chal = 1'b0;

    case (state)
      S_IDLE: begin
        // Anything other than SYNC between frames is line noise, not an error.
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) state_nxt = S_CMD;
      end

      S_CMD: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == CMD_RUN) begin
            state_nxt = S_PAYLOAD;
          end else if (i_Rx_Byte == CMD_CLEAR) begin
            state_nxt = S_CHK;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (byte_tmo) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      S_PAYLOAD: begin
        if (i_Rx_DV) begin
          if (idx_q == IDX_LAST) state_nxt = S_CHK;
        end else if (byte_tmo) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      S_CHK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte != xor_q) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end else if (cmd_q == CMD_RUN) begin
            load_chal = 1'b1;
            start_nxt = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            clear_nxt = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (byte_tmo) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      S_WAIT: begin
        // Bytes arriving during a measurement are dropped as overruns.
        if (i_Rx_DV) err_nxt = 1'b1;
        // While the start pulse is still high, a done level is left over from
        // the previous measurement and must not end this one.
        if (!o_Puf_Start && i_Puf_Done) begin
          state_nxt = S_IDLE;
        end else if (puf_tmo) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, control registers and counters
  // -------------------------------------------------------------------------
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= S_IDLE;
      cmd_q       <= '0;
      xor_q       <= '0;
      idx_q       <= '0;
      byte_tmr_q  <= '0;
      puf_tmr_q   <= '0;
      o_Challenge <= '0;
      o_Puf_Start <= 1'b0;
      o_Puf_Clear <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Err_Count <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register here samples the pre-edge values, whatever the statement order.
      state       <= state_nxt;
      o_Puf_Start <= start_nxt;
      o_Puf_Clear <= clear_nxt;
      o_Frame_Err <= err_nxt;

      if (err_nxt && (o_Err_Count != 8'hFF)) o_Err_Count <= o_Err_Count + 8'd1;

      if (load_chal) o_Challenge <= shadow_q;

      if (i_Rx_DV) begin
        case (state)
          S_CMD: begin
            cmd_q <= i_Rx_Byte;
            xor_q <= i_Rx_Byte;
            idx_q <= '0;
          end
          S_PAYLOAD: begin
            xor_q <= xor_q ^ i_Rx_Byte;
            idx_q <= idx_q + 1'b1;
          end
          default: ;
        endcase
      end

      // Inter-byte timer: restarts on every byte, so a byte arriving in the
      // expiry cycle wins over the timeout.
      if (in_frame && !i_Rx_DV && !byte_tmo) byte_tmr_q <= byte_tmr_q + 1'b1;
      else                                   byte_tmr_q <= '0;

      if ((state == S_WAIT) && !puf_tmo) puf_tmr_q <= puf_tmr_q + 1'b1;
      else                               puf_tmr_q <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Payload shadow buffer
  // -------------------------------------------------------------------------
  // NOTE: the shadow buffer has no reset; it reaches o_Challenge only after a
  // complete payload has overwritten every byte, so stale contents never leak.
  always_ff @(posedge i_Clock) begin
    if (i_Rx_DV && (state == S_PAYLOAD)) begin
      for (int i = 0; i < CHAL_BYTES; i++) begin
        if (idx_q == IDX_W'(i)) shadow_q[8*i +: 8] <= i_Rx_Byte;
      end
    end
  end

endmodule

// File: tb/tb_uart_puf_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_puf_cmd_ctrl
//
// Directed bench for uart_puf_cmd_ctrl. The stimulus process sends frames and
// pushes the expected pulse events (start / clear / error, with the cycle they
// must appear in) into a queue; a monitor on the falling clock edge pops and
// compares whenever the DUT raises one of its pulse outputs.
// Timeouts are shortened so the whole run stays small.
// ---------------------------------------------------------------------------
module tb_uart_puf_cmd_ctrl;

  localparam int CB = 4;
  localparam int BT = 40;
  localparam int PT = 200;

  typedef enum int {EV_START = 1, EV_CLEAR = 2, EV_ERR = 3} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [31:0] chal;
    logic [7:0]  cnt;
    int          cyc;
  } exp_ev_t;

  logic          clk;
  logic          rst;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          puf_done;
  logic [8*CB-1:0] chal;
  logic          puf_start;
  logic          puf_clear;
  logic          busy;
  logic          frame_err;
  logic [7:0]    err_count;

  int      total = 0;
  int      bad   = 0;
  int      cyc   = 0;
  int      err_exp = 0;
  exp_ev_t exp_q[$];

  uart_puf_cmd_ctrl #(
    .CHAL_BYTES  (CB),
    .SYNC_BYTE   (8'hA5),
    .BYTE_TIMEOUT(BT),
    .PUF_TIMEOUT (PT)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Rx_DV    (rx_dv),
    .i_Rx_Byte  (rx_byte),
    .i_Puf_Done (puf_done),
    .o_Challenge(chal),
    .o_Puf_Start(puf_start),
    .o_Puf_Clear(puf_clear),
    .o_Busy     (busy),
    .o_Frame_Err(frame_err),
    .o_Err_Count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic push_ev(input ev_kind_t k, input logic [31:0] c, input int at);
    exp_ev_t e;
    e.kind = k;
    e.chal = c;
    e.cyc  = at;
    if (k == EV_ERR && err_exp < 255) err_exp++;
    e.cnt  = 8'(err_exp);
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k);
    exp_ev_t e;
    check("event_was_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("event_kind", 32'(k), 32'(e.kind));
    check("event_cycle", 32'(cyc), 32'(e.cyc));
    if (k == EV_START) check("start_challenge", chal, e.chal);
    if (k == EV_ERR)   check("err_count_at_err", 32'(err_count), 32'(e.cnt));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (puf_start) observe(EV_START);
      if (puf_clear) observe(EV_CLEAR);
      if (frame_err) observe(EV_ERR);
    end
  end

  // ---------------- stimulus helpers ----------------
  // All helpers start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns the cycle number of the edge that sampled the byte.
  task automatic send_byte(input logic [7:0] b, output int p);
    rx_byte = b;
    rx_dv   = 1'b1;
    @(posedge clk);
    #1;
    p     = cyc;
    rx_dv = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] pay,
                            input bit with_pay, input logic [7:0] chk, output int p);
    int q;
    send_byte(8'hA5, q);
    send_byte(cmd, q);
    if (with_pay) for (int i = 0; i < CB; i++) send_byte(pay[8*i +: 8], q);
    send_byte(chk, p);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_chal"},  chal, 32'h0);
    check({tag, "_start"}, 32'(puf_start), 32'd0);
    check({tag, "_clear"}, 32'(puf_clear), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_err"},   32'(frame_err), 32'd0);
    check({tag, "_count"}, 32'(err_count), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int p, q;
    rst      = 1'b1;
    rx_dv    = 1'b0;
    rx_byte  = 8'h00;
    puf_done = 1'b0;

    idle(2);
    check_quiet("reset");
    rst = 1'b0;
    idle(2);

    // RUN with challenge 11 22 33 44; XOR of 01,11,22,33,44 is 45.
    send_frame(8'h01, 32'h44332211, 1'b1, 8'h45, p);
    push_ev(EV_START, 32'h44332211, p);
    check("busy_after_accept", 32'(busy), 32'd1);
    idle(50);
    check("busy_before_done", 32'(busy), 32'd1);
    puf_done = 1'b1;
    idle(1);
    check("busy_after_done", 32'(busy), 32'd0);
    puf_done = 1'b0;
    idle(2);

    // Same frame with a bad checksum: error, challenge unchanged.
    send_frame(8'h01, 32'h44332211, 1'b1, 8'h56, p);
    push_ev(EV_ERR, 32'h0, p);
    check("chal_kept_on_bad_chk", chal, 32'h44332211);
    check("busy_on_bad_chk", 32'(busy), 32'd0);
    idle(2);

    // CLEAR frame, then an unknown command, then a stray non-SYNC byte.
    send_frame(8'h02, 32'h0, 1'b0, 8'h02, p);
    push_ev(EV_CLEAR, 32'h0, p);
    check("busy_on_clear", 32'(busy), 32'd0);
    idle(2);
    send_byte(8'hA5, q);
    send_byte(8'h07, p);
    push_ev(EV_ERR, 32'h0, p);
    idle(1);
    send_byte(8'h02, q);
    idle(3);

    // Bytes arriving exactly in the timer expiry cycle are still accepted.
    send_byte(8'hA5, q);
    idle(BT - 1);
    send_byte(8'h02, q);
    idle(BT - 1);
    send_byte(8'h02, p);
    push_ev(EV_CLEAR, 32'h0, p);
    idle(2);

    // Stalled RUN frame: error BT clocks after the last byte.
    send_byte(8'hA5, q);
    send_byte(8'h01, q);
    send_byte(8'h11, p);
    push_ev(EV_ERR, 32'h0, p + BT);
    idle(BT + 5);

    // Next frame is accepted; A5 inside the payload is data.
    // XOR of 01,A5,00,FF,10 is 4B.
    send_frame(8'h01, 32'h10FF00A5, 1'b1, 8'h4B, p);
    push_ev(EV_START, 32'h10FF00A5, p);
    puf_done = 1'b1;
    idle(1);
    puf_done = 1'b0;
    check("stale_done_ignored", 32'(busy), 32'd1);
    idle(4);
    send_byte(8'hA5, q);
    push_ev(EV_ERR, 32'h0, q);
    check("busy_after_overrun", 32'(busy), 32'd1);
    push_ev(EV_ERR, 32'h0, p + PT);
    idle(p + PT - 1 - cyc);
    check("busy_before_puf_tmo", 32'(busy), 32'd1);
    idle(3);
    check("busy_after_puf_tmo", 32'(busy), 32'd0);
    check("chal_after_puf_tmo", chal, 32'h10FF00A5);

    // Drive the error counter into saturation.
    for (int i = 0; i < 260; i++) begin
      send_byte(8'hA5, q);
      send_byte(8'h07, p);
      push_ev(EV_ERR, 32'h0, p);
    end
    idle(2);
    check("err_count_saturated", 32'(err_count), 32'hFF);

    // Asynchronous reset in the middle of a payload.
    send_byte(8'hA5, q);
    send_byte(8'h01, q);
    send_byte(8'h11, q);
    send_byte(8'h22, q);
    #2;
    rst = 1'b1;
    #1;
    check_quiet("async_reset");
    err_exp = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    send_frame(8'h01, 32'h44332211, 1'b1, 8'h45, p);
    push_ev(EV_START, 32'h44332211, p);
    idle(2);
    puf_done = 1'b1;
    idle(1);
    puf_done = 1'b0;
    check("busy_after_reset_run", 32'(busy), 32'd0);
    idle(3);

    check("pending_events", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
